// File: rtl/wallace_mul_pkg.sv
// Shared widths and tree-sizing helpers for the pipelined Wallace multiplier.
package wallace_mul_pkg;

    localparam int unsigned WA_DEF   = 24;
    localparam int unsigned WB_DEF   = 26;
    localparam int unsigned TAGW_DEF = 4;

    // Rows left after applying 'levels' 3:2 levels to 'rows' rows.
    function automatic int unsigned wallace_rows(input int unsigned rows, input int unsigned levels);
        int unsigned r;
        r = rows;
        for (int unsigned l = 0; l < levels; l++) begin
            if (r > 2) r = r - r / 3;
        end
        return r;
    endfunction

    function automatic int unsigned wallace_levels(input int unsigned rows);
        int unsigned r;
        int unsigned lv;
        r  = rows;
        lv = 0;
        while (r > 2) begin
            r  = r - r / 3;
            lv = lv + 1;
        end
        return lv;
    endfunction

    localparam int unsigned S1_LEVELS = wallace_levels(WB_DEF) / 2;

endpackage

// File: rtl/wallace_csa32.sv
// One row of full adders: three operands in, sum and left-shifted carry out.
module wallace_csa32 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);

    assign s  = x ^ y ^ c;
    assign co = ((x & y) | (x & c) | (y & c)) << 1;

endmodule

// File: rtl/wallace_mul_pipe.sv
// Three-stage signed/unsigned Wallace-tree multiplier with a single global
// pipeline enable driven by the output handshake.
module wallace_mul_pipe
    import wallace_mul_pkg::*;
#(
    parameter int unsigned WA   = WA_DEF,
    parameter int unsigned WB   = WB_DEF,
    parameter int unsigned TAGW = TAGW_DEF
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WA-1:0]     a,
    input  logic [WB-1:0]     b,
    input  logic              sgn,
    input  logic [TAGW-1:0]   tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WA+WB-1:0]  z,
    output logic [TAGW-1:0]   tag_out
);

    localparam int unsigned N       = WA + WB;
    // One row per multiplier bit plus the Baugh-Wooley constant row.
    localparam int unsigned NROWS   = WB + 1;
    localparam int unsigned TOT     = wallace_levels(NROWS);
    localparam int unsigned SPLIT   = wallace_levels(WB) / 2;
    localparam int unsigned S1_ROWS = wallace_rows(NROWS, SPLIT);
    localparam logic [N-1:0] BW_CONST = (N'(1) << (WA - 1)) + (N'(1) << (WB - 1)) + (N'(1) << (N - 1));

    logic                 en;
    logic [NROWS*N-1:0]   pp;
    logic [N-1:0]         pp_row;
    logic [S1_ROWS*N-1:0] s1_d, s1_q;
    logic [2*N-1:0]       s2_d;
    logic [N-1:0]         s2_sum, s2_car;
    logic [TAGW-1:0]      s1_tag, s2_tag;
    logic                 s1_v, s2_v;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Signed mode inverts the MSB row/column products, except their crossing bit.
    always_comb begin
        pp     = '0;
        pp_row = '0;
        for (int unsigned i = 0; i < WB; i++) begin
            pp_row = '0;
            for (int unsigned j = 0; j < WA; j++) begin
                pp_row[j] = (a[j] & b[i]) ^ (sgn & ((i == WB - 1) != (j == WA - 1)));
            end
            pp[i*N +: N] = pp_row << i;
        end
        pp[WB*N +: N] = sgn ? BW_CONST : '0;
    end

    for (genvar l = 0; l < TOT; l++) begin : g_lvl
        localparam int unsigned R  = wallace_rows(NROWS, l);
        localparam int unsigned G  = R / 3;
        localparam int unsigned RN = R - G;

        logic [R*N-1:0]  din;
        logic [RN*N-1:0] dout;

        if (l == 0) begin : g_src
            assign din = pp;
        end else if (l == SPLIT) begin : g_src
            assign din = s1_q;
        end else begin : g_src
            assign din = g_lvl[l-1].dout;
        end

        for (genvar g = 0; g < G; g++) begin : g_csa
            wallace_csa32 #(.W(N)) u_csa (
                .x  (din[(3*g)*N +: N]),
                .y  (din[(3*g+1)*N +: N]),
                .c  (din[(3*g+2)*N +: N]),
                .s  (dout[(2*g)*N +: N]),
                .co (dout[(2*g+1)*N +: N])
            );
        end

        if (R % 3 != 0) begin : g_pass
            assign dout[RN*N-1 : 2*G*N] = din[R*N-1 : 3*G*N];
        end
    end

    assign s1_d = g_lvl[SPLIT-1].dout;
    assign s2_d = g_lvl[TOT-1].dout;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            out_valid <= 1'b0;
            z         <= '0;
            tag_out   <= '0;
        end else if (en) begin
            s1_v      <= in_valid & in_ready;
            s2_v      <= s1_v;
            out_valid <= s2_v;
            z         <= s2_sum + s2_car;
            tag_out   <= s2_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_q   <= s1_d;
            s1_tag <= tag_in;
            s2_sum <= s2_d[N-1:0];
            s2_car <= s2_d[2*N-1:N];
            s2_tag <= s1_tag;
        end
    end

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Directed and randomised checks of wallace_mul_pipe at 24x26 and 8x8.
module tb_wallace_mul_pipe;

    logic        clk, clrn;
    logic        in_valid, in_ready, sgn, out_valid, out_ready;
    logic [23:0] op_a;
    logic [25:0] op_b;
    logic [3:0]  tag_in, tag_out;
    logic [49:0] z;

    logic        s_in_valid, s_in_ready, s_sgn, s_out_valid, s_out_ready;
    logic [7:0]  s_a, s_b;
    logic [3:0]  s_tag_in, s_tag_out;
    logic [15:0] s_z;

    int unsigned n_vec, n_err;

    wallace_mul_pipe #(.WA(24), .WB(26), .TAGW(4)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .a(op_a), .b(op_b), .sgn(sgn), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .tag_out(tag_out)
    );

    wallace_mul_pipe #(.WA(8), .WB(8), .TAGW(4)) dut_s (
        .clk(clk), .clrn(clrn), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .sgn(s_sgn), .tag_in(s_tag_in),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .z(s_z), .tag_out(s_tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input int unsigned wx, input int unsigned wy, input logic s);
        logic [63:0] mx, my, ex, ey, p;
        mx = (64'd1 << wx) - 64'd1;
        my = (64'd1 << wy) - 64'd1;
        ex = x & mx;
        ey = y & my;
        if (s && ex[wx-1]) ex = ex | ~mx;
        if (s && ey[wy-1]) ey = ey | ~my;
        p = ex * ey;
        return p & ((64'd1 << (wx + wy)) - 64'd1);
    endfunction

    task automatic rand_run(input int unsigned which, input int unsigned n);
        logic [63:0] q_z[$];
        logic [3:0]  q_t[$];
        logic [63:0] ra, rb, gz, ez;
        logic [3:0]  rt, gt, et;
        logic        rs, v, r, rdy, ov;
        int unsigned sent, guard, wa, wb;
        sent  = 0;
        guard = 0;
        wa    = (which == 0) ? 24 : 8;
        wb    = (which == 0) ? 26 : 8;
        while ((sent < n || q_z.size() != 0) && guard < 8 * n + 100) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(1, 0));
            rt = 4'($urandom_range(15, 0));
            v  = (sent < n) && ($urandom_range(3, 0) != 0);
            r  = (sent >= n) || ($urandom_range(3, 0) != 0);
            if (which == 0) begin
                in_valid = v; op_a = ra[23:0]; op_b = rb[25:0]; sgn = rs; tag_in = rt; out_ready = r;
            end else begin
                s_in_valid = v; s_a = ra[7:0]; s_b = rb[7:0]; s_sgn = rs; s_tag_in = rt; s_out_ready = r;
            end
            #1;
            if (which == 0) begin
                rdy = in_ready; ov = out_valid; gz = 64'(z); gt = tag_out;
            end else begin
                rdy = s_in_ready; ov = s_out_valid; gz = 64'(s_z); gt = s_tag_out;
            end
            if (ov && r) begin
                ez = (q_z.size() != 0) ? q_z.pop_front() : ~gz;
                et = (q_t.size() != 0) ? q_t.pop_front() : ~gt;
                check((which == 0) ? "rand_z_24x26" : "rand_z_8x8", gz, ez);
                check((which == 0) ? "rand_tag_24x26" : "rand_tag_8x8", 64'(gt), 64'(et));
            end
            if (v && rdy) begin
                q_z.push_back(ref_mul(ra, rb, wa, wb, rs));
                q_t.push_back(rt);
                sent++;
            end
            step();
            guard++;
        end
        check("rand_drain", 64'(q_z.size()), 64'd0);
        if (which == 0) in_valid = 1'b0; else s_in_valid = 1'b0;
    endtask

    logic [23:0] t2_a [3] = '{24'hffffff, 24'h800000, 24'hffffff};
    logic [25:0] t2_b [3] = '{26'h3ffffff, 26'h2000000, 26'h3};
    logic [49:0] t2_z [3] = '{50'h1, 50'h1000000000000, 50'h3fffffffffffd};

    logic [23:0] bp_a [5] = '{24'd3, 24'd7, 24'd100, 24'h1000, 24'hfffffe};
    logic [25:0] bp_b [5] = '{26'd5, 26'd9, 26'd200, 26'h10, 26'd5};
    logic        bp_s [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [49:0] bp_z [5] = '{50'hf, 50'h3f, 50'h4e20, 50'h10000, 50'h3fffffffffff6};
    int          pat  [5] = '{1, 0, 1, 0, 1};

    initial begin
        int unsigned idx, rx, seen;
        logic [49:0] held_z;
        logic [3:0]  held_t;
        logic        stall;
        int          k, ev;

        n_vec = 0; n_err = 0;
        clrn = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sgn = 1'b0; tag_in = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_sgn = 1'b0; s_tag_in = '0; s_out_ready = 1'b1;
        #1 clrn = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_z", 64'(z), 64'd0);
        check("rst_tag", 64'(tag_out), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #20 clrn = 1'b1;
        step();

        // Unsigned corner and latency.
        op_a = 24'hffffff; op_b = 26'h3ffffff; sgn = 1'b0; tag_in = 4'h5; in_valid = 1'b1;
        #1 check("lat_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("lat_c1", 64'(out_valid), 64'd0);
        step();
        check("lat_c2", 64'(out_valid), 64'd0);
        step();
        check("lat_c3_valid", 64'(out_valid), 64'd1);
        check("ucorner_z", 64'(z), 64'h3fffffb000001);
        check("ucorner_tag", 64'(tag_out), 64'h5);
        step();
        check("lat_c4", 64'(out_valid), 64'd0);

        // Signed corners back to back.
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                in_valid = 1'b1; op_a = t2_a[c]; op_b = t2_b[c]; sgn = 1'b1; tag_in = 4'(c + 1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (c >= 2 && c < 5) begin
                check("sgn_valid", 64'(out_valid), 64'd1);
                check("sgn_z", 64'(z), 64'(t2_z[c-2]));
                check("sgn_tag", 64'(tag_out), 64'(c - 1));
            end else if (c == 5) begin
                check("sgn_tail", 64'(out_valid), 64'd0);
            end
        end

        // Backpressure: stall four cycles once the first result shows.
        idx = 0; rx = 0; held_z = '0; held_t = '0;
        for (int c = 0; c < 16; c++) begin
            stall = (c >= 3 && c < 7);
            out_ready = ~stall;
            if (idx < 5) begin
                in_valid = 1'b1; op_a = bp_a[idx]; op_b = bp_b[idx]; sgn = bp_s[idx]; tag_in = 4'(idx + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall) check("bp_in_ready", 64'(in_ready), 64'd0);
            if (stall && c > 3) begin
                check("bp_hold_z", 64'(z), 64'(held_z));
                check("bp_hold_tag", 64'(tag_out), 64'(held_t));
            end
            if (out_valid && out_ready) begin
                if (rx < 5) begin
                    check("bp_z", 64'(z), 64'(bp_z[rx]));
                    check("bp_tag", 64'(tag_out), 64'(rx + 1));
                end else begin
                    check("bp_extra", 64'(rx), 64'd4);
                end
                rx++;
            end
            if (in_valid && in_ready) idx++;
            held_z = z;
            held_t = tag_out;
            step();
        end
        check("bp_count", 64'(rx), 64'd5);

        // Bubbles: valid pattern must reappear three cycles later.
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 5) ? (pat[c] != 0) : 1'b0;
            op_a = 24'(c + 1); op_b = 26'd2; sgn = 1'b0; tag_in = 4'(c);
            step();
            if (c >= 2) begin
                k  = c - 2;
                ev = (k < 5) ? pat[k] : 0;
                check("bub_valid", 64'(out_valid), 64'(ev));
                if (ev != 0) check("bub_z", 64'(z), 64'(2 * k + 2));
            end
        end

        // Reset with two operations in flight.
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; op_a = 24'd9; op_b = 26'd9; sgn = 1'b0; tag_in = 4'h7;
            step();
        end
        in_valid = 1'b0;
        #1 clrn = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_z", 64'(z), 64'd0);
        check("mid_rst_tag", 64'(tag_out), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        #1 clrn = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", 64'(seen), 64'd0);
        check("mid_rst_ready_after", 64'(in_ready), 64'd1);

        rand_run(0, 10000);
        rand_run(1, 10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
